// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Zero-extension to 32 bits leaves the XOR reduction unchanged for narrower words.
  function automatic logic parity_bit(input logic [31:0] data, input logic typ);
    return (typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - byte latch, right-shift register and bit counter for the TX path
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  cur_bit,
  output logic                  next_bit,
  output logic                  done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         bit_cnt;

  assign shifted  = shift_reg >> 1;
  assign cur_bit  = shift_reg[0];
  // The output flop is loaded one bit ahead of the shift, so it needs the post-shift LSB.
  assign next_bit = shifted[0];
  assign done     = (bit_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      data      <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      data      <= load_data;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= shifted;
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter, one clk per bit, optional parity
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_t             state;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  cur_bit;
  logic                  next_bit;
  logic                  done;

  assign accept = Data_Valid && !Busy;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (state == DATA),
    .load_data (P_DATA),
    .data      (data_q),
    .cur_bit   (cur_bit),
    .next_bit  (next_bit),
    .done      (done)
  );

  // TX_OUT and Busy are assigned alongside each transition so they describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state     <= START;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            par_en_q  <= Par_En;
            par_typ_q <= Par_Typ;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= cur_bit;
          Busy   <= 1'b1;
        end
        DATA: begin
          if (!done) begin
            TX_OUT <= next_bit;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= parity_bit(32'(data_q), par_typ_q);
          end else begin
            state  <= STOP;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmitter that serializes one parallel byte per frame onto the idle-high line consumed by the UART receiver.
- Runs on the TX bit clock: one `clk` cycle per transmitted bit, no oversampling.
- Frame format: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity bit, one stop bit. This matches the receiver's `Par_En`/`Par_Typ` conventions.
- Sits between the system's TX-side data source (register file / FIFO read port) and the serial pin.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  TX bit clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on accept.
- Data_Valid  input  1  request to send P_DATA.
- Par_En  input  1  1 = parity bit inserted; sampled on accept.
- Par_Typ  input  1  0 = even, 1 = odd; sampled on accept.
- TX_OUT  output  1  serial line, registered, idle high.
- Busy  output  1  registered; 1 = transmitter cannot accept a new frame this cycle.

## Operation
- Accept condition: `Data_Valid && !Busy` at a rising edge. On accept, P_DATA, Par_En and Par_Typ are latched into internal registers. Later input changes do not affect the frame in flight.
- Data_Valid while Busy=1 is ignored. It is not queued; the source must hold or re-present it.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1. On accept → START.
  - START: TX_OUT=0, one cycle → DATA.
  - DATA: TX_OUT=shift_reg[0], shifting right each cycle. A bit counter runs 0..DATA_WIDTH-1. After the last bit → PARITY if the latched Par_En=1, else → STOP.
  - PARITY: TX_OUT = ^data for even, ~^data for odd; computed from the latched byte; one cycle → STOP.
  - STOP: TX_OUT=1, one cycle. On accept → START (back-to-back); else → IDLE.
- Busy=1 in START, DATA and PARITY. Busy=0 in IDLE and STOP, so a new frame can be accepted during the stop bit.
- The bit counter is $clog2(DATA_WIDTH) bits wide. It resets to 0 on entry to DATA.

## Timing
- Reset values: TX_OUT=1, Busy=0, state=IDLE, bit counter=0, latched data=0.
- Reset mid-frame: after the edge with rst=1, TX_OUT=1 and Busy=0. The in-flight frame is abandoned with no truncated stop bit. rst takes priority over accept in the same cycle.
- Latency: accept at edge N → TX_OUT=0 and Busy=1 from edge N.
- Frame length: 10 cycles without parity, 11 with parity (DATA_WIDTH=8).
- Back-to-back frames have no extra idle cycles. The stop bit of frame k is immediately followed by the start bit of frame k+1.
- TX_OUT and Busy are driven directly from flops, with no combinational path from inputs.

## Structure
- Shared package `uart_pkg`:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - PAR_EVEN=0 / PAR_ODD=1 constants.
  - `parity_bit(data, typ)` function, shared with the receiver's parity checker.
- One natural sub-module, `uart_tx_serializer`: load/shift register plus bit counter, with `load`, `shift`, `done` ports. The FSM and output muxing stay in the top.

## Test plan
- 0xA5, Par_En=1, Par_Typ=0 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1. Busy high for 10 cycles, then low during stop.
- 0xA5, Par_En=1, Par_Typ=1 → same sequence but parity bit=1. 0x00 odd parity → parity bit=1.
- 0x3C, Par_En=0 → 0,0,0,1,1,1,1,0,0,1: 10 cycles, no parity slot.
- Back-to-back: Data_Valid held high with 0x55 then 0xFF, no parity → 20 contiguous cycles. The second start bit directly follows the first stop bit.
- Data_Valid pulsed with 0x12 during DATA of a 0xA5 frame → ignored; TX_OUT carries only 0xA5, then returns to idle 1.
- rst=1 during bit 4 of a frame → next cycle TX_OUT=1, Busy=0. A subsequent 0x81 frame transmits correctly.
